cnn_result_ctrl: RTL and testbench

CNN_RESULT_CTRL -- requirements
Module: cnn_result_ctrl

---
 rtl/cnn_result_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cnn_result_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_result_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_result_ctrl
//
// Result controller for a small CNN classifier. On start_i it asks the image
// loader for a new frame, waits (bounded by TIMEOUT) for the dense layer to
// present all N_CLASS scores, finds the arg-max one score per cycle, publishes
// the winning class and drives an LED display in one of three modes.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   reset          : synchronous, active-high reset
//   start_i        : one-cycle request to classify the next image
//   mode_i         : display mode (00 class, 01 score scan, 10 max score, 11 = 00)
//   dense_valid_i  : dense_data_i carries valid scores this cycle
//   dense_data_i   : N_CLASS packed scores, score k at [k*DATA_BITS +: DATA_BITS]
//   frame_start_o  : one-cycle pulse to the image loader
//   led_o          : registered display value
//   class_o        : winning class index
//   class_valid_o  : one-cycle pulse when class_o updates
//   busy_o         : high while waiting for scores or searching the maximum
//   timeout_o      : sticky, set when the dense layer never answered
//   frame_cnt_o    : number of completed classifications (wraps)
// -----------------------------------------------------------------------------
module cnn_result_ctrl #(
    parameter int N_CLASS    = 7,
    parameter int DATA_BITS  = 8,
    parameter int DWELL      = 10000,
    parameter int TIMEOUT    = 1048576,
    parameter int SIGNED_CMP = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_i,
    input  logic [1:0]                   mode_i,
    input  logic                         dense_valid_i,
    input  logic [N_CLASS*DATA_BITS-1:0] dense_data_i,
    output logic                         frame_start_o,
    output logic [DATA_BITS-1:0]         led_o,
    output logic [3:0]                   class_o,
    output logic                         class_valid_o,
    output logic                         busy_o,
    output logic                         timeout_o,
    output logic [15:0]                  frame_cnt_o
);

    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int DWELL_W = $clog2(DWELL + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [3:0]         LAST_IDX   = 4'(N_CLASS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ARGMAX = 2'd2,
        S_SHOW   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [DATA_BITS-1:0]   score_q [N_CLASS];
    logic [DATA_BITS-1:0]   score_d [N_CLASS];
    logic [DATA_BITS-1:0]   dense_score [N_CLASS];
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   run_max_q, run_max_d;
    logic [3:0]             run_idx_q, run_idx_d;
    logic                   commit_q, commit_d;
    logic [3:0]             class_q, class_d;
    logic [DATA_BITS-1:0]   max_q, max_d;
    logic                   class_valid_q, class_valid_d;
    logic                   frame_start_q, frame_start_d;
    logic                   timeout_q, timeout_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic [3:0]             scan_k_q, scan_k_d;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic [1:0]             mode_q, mode_d;
    logic [DATA_BITS-1:0]   led_q, led_d;

    logic [DATA_BITS-1:0]   cur_score;
    logic [DATA_BITS-1:0]   scan_score;
    logic [3:0]             scan_k_cur;
    logic [DWELL_W-1:0]     dwell_cur;
    logic                   mode_change;

    // Slice the packed dense bus into one score per class.
    for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_unpack
        assign dense_score[gi] = dense_data_i[gi*DATA_BITS +: DATA_BITS];
    end

    function automatic logic greater(input logic [DATA_BITS-1:0] a,
                                     input logic [DATA_BITS-1:0] b);
        if (SIGNED_CMP != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        score_d       = score_q;
        idx_d         = idx_q;
        run_max_d     = run_max_q;
        run_idx_d     = run_idx_q;
        commit_d      = 1'b0;
        class_d       = class_q;
        max_d         = max_q;
        class_valid_d = 1'b0;
        frame_start_d = 1'b0;
        timeout_d     = timeout_q;
        frame_cnt_d   = frame_cnt_q;
        scan_k_d      = scan_k_q;
        dwell_d       = dwell_q;
        mode_d        = mode_i;
        led_d         = led_q;

        // Score under examination by the arg-max walk.
        cur_score = score_q[0];
        for (int i = 0; i < N_CLASS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_score = score_q[i];
            end
        end

        // A mode change restarts the scan this very cycle, so the display
        // already shows score 0 on the edge that sees the new mode.
        mode_change = (mode_i != mode_q);
        scan_k_cur  = mode_change ? 4'd0 : scan_k_q;
        dwell_cur   = mode_change ? '0 : dwell_q;

        scan_score = score_q[0];
        for (int i = 0; i < N_CLASS; i++) begin
            if (scan_k_cur == 4'(i)) begin
                scan_score = score_q[i];
            end
        end

        if (state_q == S_SHOW) begin
            scan_k_d = scan_k_cur;
            if (dwell_cur == DWELL_LAST) begin
                dwell_d  = '0;
                scan_k_d = (scan_k_cur == LAST_IDX) ? 4'd0 : scan_k_cur + 4'd1;
            end else begin
                dwell_d = dwell_cur + DWELL_W'(1);
            end
            // Hold the display until the new result has been committed so
            // that freshly captured scores never leak out early.
            if (!commit_q) begin
                case (mode_i)
                    2'b01:   led_d = scan_score;
                    2'b10:   led_d = max_q;
                    default: led_d = DATA_BITS'(class_q);
                endcase
            end
        end else begin
            scan_k_d = scan_k_cur;
            dwell_d  = dwell_cur;
        end

        case (state_q)
            S_IDLE, S_SHOW: begin
                if (start_i) begin
                    frame_start_d = 1'b1;
                    timeout_d     = 1'b0;
                    wait_cnt_d    = '0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // Capture has priority over the timeout on the same cycle.
                if (dense_valid_i) begin
                    score_d = dense_score;
                    idx_d   = 4'd0;
                    state_d = S_ARGMAX;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_ARGMAX: begin
                // Index 0 seeds the running maximum; strict greater-than
                // keeps the lowest index on ties.
                if (idx_q == 4'd0 || greater(cur_score, run_max_q)) begin
                    run_max_d = cur_score;
                    run_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d  = S_SHOW;
                    commit_d = 1'b1;
                    scan_k_d = 4'd0;
                    dwell_d  = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Publish the result one edge after the walk has finished.
        if (commit_q) begin
            class_d       = run_idx_q;
            max_d         = run_max_q;
            class_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                score_q[i] <= '0;
            end
            idx_q         <= '0;
            run_max_q     <= '0;
            run_idx_q     <= '0;
            commit_q      <= 1'b0;
            class_q       <= '0;
            max_q         <= '0;
            class_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            frame_cnt_q   <= '0;
            scan_k_q      <= '0;
            dwell_q       <= '0;
            mode_q        <= '0;
            led_q         <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            score_q       <= score_d;
            idx_q         <= idx_d;
            run_max_q     <= run_max_d;
            run_idx_q     <= run_idx_d;
            commit_q      <= commit_d;
            class_q       <= class_d;
            max_q         <= max_d;
            class_valid_q <= class_valid_d;
            frame_start_q <= frame_start_d;
            timeout_q     <= timeout_d;
            frame_cnt_q   <= frame_cnt_d;
            scan_k_q      <= scan_k_d;
            dwell_q       <= dwell_d;
            mode_q        <= mode_d;
            led_q         <= led_d;
        end
    end

    assign frame_start_o = frame_start_q;
    assign led_o         = led_q;
    assign class_o       = class_q;
    assign class_valid_o = class_valid_q;
    assign busy_o        = (state_q == S_WAIT) || (state_q == S_ARGMAX);
    assign timeout_o     = timeout_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_cnn_result_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cnn_result_ctrl. Two instances share all inputs: one compares
// scores as signed, the other as unsigned. Stimulus pushes the expected
// classification of each frame into a per-instance queue; a monitor pops and
// compares whenever class_valid_o is seen.
// -----------------------------------------------------------------------------
module tb_cnn_result_ctrl;

    localparam int N  = 7;
    localparam int DB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            start_i;
    logic [1:0]      mode_i;
    logic            dense_valid_i;
    logic [N*DB-1:0] dense_data_i;

    logic        fs_w    [2];
    logic [7:0]  led_w   [2];
    logic [3:0]  class_w [2];
    logic        cv_w    [2];
    logic        busy_w  [2];
    logic        to_w    [2];
    logic [15:0] fc_w    [2];

    cnn_result_ctrl #(.N_CLASS(N), .DATA_BITS(DB), .DWELL(4), .TIMEOUT(16), .SIGNED_CMP(1)) u_signed (
        .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i),
        .dense_valid_i(dense_valid_i), .dense_data_i(dense_data_i),
        .frame_start_o(fs_w[0]), .led_o(led_w[0]), .class_o(class_w[0]),
        .class_valid_o(cv_w[0]), .busy_o(busy_w[0]), .timeout_o(to_w[0]),
        .frame_cnt_o(fc_w[0])
    );

    cnn_result_ctrl #(.N_CLASS(N), .DATA_BITS(DB), .DWELL(4), .TIMEOUT(16), .SIGNED_CMP(0)) u_unsigned (
        .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i),
        .dense_valid_i(dense_valid_i), .dense_data_i(dense_data_i),
        .frame_start_o(fs_w[1]), .led_o(led_w[1]), .class_o(class_w[1]),
        .class_valid_o(cv_w[1]), .busy_o(busy_w[1]), .timeout_o(to_w[1]),
        .frame_cnt_o(fc_w[1])
    );

    typedef struct {
        int cls;
        int cyc;
        int fcnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fcnt_m   [2];
    int last_cls [2];
    int last_max [2];
    logic [7:0] sc [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0d expected=%0d cycle=%0d", name, inst, act, exp, cyc);
        end
    endfunction

    // Reference: convert scores to plain integers, take the maximum, then the
    // first index holding that maximum.
    function automatic void ref_argmax(input bit sgn, output int cls, output int mx);
        int v [N];
        int best;
        for (int i = 0; i < N; i++) begin
            v[i] = int'(sc[i]);
            if (sgn && v[i] >= 128) v[i] = v[i] - 256;
        end
        best = v[0];
        for (int i = 1; i < N; i++) if (v[i] > best) best = v[i];
        cls = 0;
        for (int i = N - 1; i >= 0; i--) if (v[i] == best) cls = i;
        mx = best & 255;
    endfunction

    // Monitor: one popped transaction per class_valid_o pulse.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (cv_w[i]) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_class_valid inst=%0d got_class=%0d expected=none cycle=%0d",
                             i, class_w[i], cyc);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("class_o", i, int'(class_w[i]), e.cls);
                    chk("frame_cnt_o", i, int'(fc_w[i]), e.fcnt);
                    chk("class_valid_cycle", i, cyc, e.cyc);
                    $display("txn inst=%0d class=%0d frame_cnt=%0d cycle=%0d",
                             i, class_w[i], fc_w[i], cyc);
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("frame_start_pulse", k, int'(fs_w[k]), 1);
            chk("busy_after_start", k, int'(busy_w[k]), 1);
            chk("timeout_cleared", k, int'(to_w[k]), 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("frame_start_one_cycle", k, int'(fs_w[k]), 0);
    endtask

    // Drive one dense_valid_i cycle from sc[] and queue the expectations.
    task automatic send();
        int c;
        int m;
        exp_t e;
        for (int i = 0; i < N; i++) dense_data_i[i*DB +: DB] = sc[i];
        dense_valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ref_argmax(k == 0, c, m);
            fcnt_m[k]   = (fcnt_m[k] + 1) % 65536;
            e.cls       = c;
            e.cyc       = cyc + 9;
            e.fcnt      = fcnt_m[k];
            last_cls[k] = c;
            last_max[k] = m;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk); #1 dense_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL class_valid_missing pending=%0d/%0d expected=0/0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_led_result();
        for (int k = 0; k < 2; k++) begin
            if (mode_i == 2'b10) chk("led_max", k, int'(led_w[k]), last_max[k]);
            else                 chk("led_class", k, int'(led_w[k]), last_cls[k]);
        end
    endtask

    task automatic check_zero();
        for (int k = 0; k < 2; k++) begin
            chk("rst_led", k, int'(led_w[k]), 0);
            chk("rst_class", k, int'(class_w[k]), 0);
            chk("rst_class_valid", k, int'(cv_w[k]), 0);
            chk("rst_frame_start", k, int'(fs_w[k]), 0);
            chk("rst_busy", k, int'(busy_w[k]), 0);
            chk("rst_timeout", k, int'(to_w[k]), 0);
            chk("rst_frame_cnt", k, int'(fc_w[k]), 0);
        end
    endtask

    task automatic check_led_zero_all_modes();
        for (int m = 0; m < 3; m++) begin
            @(posedge clk); #1 mode_i = 2'(m);
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < 2; k++) chk("led_zero_no_result", k, int'(led_w[k]), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        start_i       = 1'b0;
        mode_i        = 2'b00;
        dense_valid_i = 1'b0;
        dense_data_i  = '0;
        for (int k = 0; k < 2; k++) begin
            fcnt_m[k]   = 0;
            last_cls[k] = 0;
            last_max[k] = 0;
        end

        // Reset state, and no display value before any result.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero();
        check_led_zero_all_modes();

        // Signed/unsigned arg-max with a tie, class display.
        mode_i = 2'b00;
        do_start();
        @(posedge clk); #1;
        sc = '{8'd3, 8'd9, 8'hFE, 8'd9, 8'd0, 8'd1, 8'd5};
        send();
        wait_done();
        chk("tie_class_signed", 0, int'(class_w[0]), 1);
        chk("tie_led_signed", 0, int'(led_w[0]), 1);
        chk("first_frame_cnt", 0, int'(fc_w[0]), 1);
        check_led_result();

        // 0x80 is largest unsigned, smallest signed; max-score display.
        mode_i = 2'b10;
        do_start();
        @(posedge clk); #1;
        sc = '{8'h80, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send();
        wait_done();
        chk("unsigned_class", 1, int'(class_w[1]), 0);
        chk("unsigned_led_max", 1, int'(led_w[1]), 128);
        chk("signed_class", 0, int'(class_w[0]), 1);
        check_led_result();

        // Score scan: 4 cycles per score, wrapping after score 6.
        @(posedge clk); #1 mode_i = 2'b01;
        @(posedge clk);
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) chk("scan_led", k, int'(led_w[k]), int'(sc[(j / 4) % N]));
        end

        // start_i and dense_valid_i during ARGMAX are ignored.
        mode_i = 2'b00;
        do_start();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) sc[i] = 8'($urandom_range(0, 255));
        send();
        @(posedge clk); #1;
        start_i       = 1'b1;
        dense_valid_i = 1'b1;
        for (int i = 0; i < N; i++) dense_data_i[i*DB +: DB] = ~sc[i];
        @(posedge clk); #1;
        start_i       = 1'b0;
        dense_valid_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("no_pulse_in_argmax", k, int'(fs_w[k]), 0);
            chk("busy_in_argmax", k, int'(busy_w[k]), 1);
        end
        wait_done();
        check_led_result();
        repeat (12) @(posedge clk);

        // Timeout after 16 WAIT cycles; class held.
        do_start();
        repeat (14) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("busy_before_timeout", k, int'(busy_w[k]), 1);
            chk("timeout_not_yet", k, int'(to_w[k]), 0);
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("timeout_set", k, int'(to_w[k]), 1);
            chk("idle_after_timeout", k, int'(busy_w[k]), 0);
            chk("class_held_timeout", k, int'(class_w[k]), last_cls[k]);
        end

        // Next start clears timeout; capture on the timeout cycle wins.
        do_start();
        repeat (14) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) sc[i] = 8'($urandom_range(0, 255));
        send();
        wait_done();
        for (int k = 0; k < 2; k++) chk("capture_beats_timeout", k, int'(to_w[k]), 0);
        check_led_result();

        // Random frames, including tie-heavy score sets.
        for (int f = 0; f < 20; f++) begin
            case ($urandom_range(0, 2))
                0:       mode_i = 2'b00;
                1:       mode_i = 2'b10;
                default: mode_i = 2'b11;
            endcase
            do_start();
            @(posedge clk); #1;
            repeat ($urandom_range(0, 5)) begin
                @(posedge clk); #1;
            end
            for (int i = 0; i < N; i++) begin
                if (f % 3 == 0) sc[i] = 8'($urandom_range(0, 3));
                else            sc[i] = 8'($urandom_range(0, 255));
            end
            send();
            wait_done();
            check_led_result();
        end

        // Reset at ARGMAX cycle 3 aborts the frame.
        mode_i = 2'b10;
        do_start();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) sc[i] = 8'($urandom_range(0, 255));
        send();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            fcnt_m[k]   = 0;
            last_cls[k] = 0;
            last_max[k] = 0;
        end
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_zero();
        repeat (12) @(posedge clk);
        check_led_zero_all_modes();

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL queue_empty_at_end pending=%0d/%0d expected=0/0", q0.size(), q1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
